cpu_multicycle: RTL and testbench

Parametrised multi-cycle successor to the single-cycle 16-bit CPU top. Executes the same 16-bit instruction format over a configurable data width, sequenced by an internal FSM through one shared instruction/data memory port with a valid/ready handshake, so it tolerates wait-state memories. Sits at the top of the CPU hierarchy, between the board clock/reset and an external memory model or controller.

---
 rtl/cpu_pkg.sv | 51 +++++
 rtl/cpu_alu.sv | 30 +++
 rtl/cpu_multicycle.sv | 165 ++++++++++++++++
 tb/tb_cpu_multicycle.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU: opcodes, R-type functs, FSM states
// and ALU operations.
package cpu_pkg;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_LW    = 4'h2;
    localparam logic [3:0] OP_SW    = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_BNE   = 4'h5;
    localparam logic [3:0] OP_JMP   = 4'h6;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] FN_ADD = 3'd0;
    localparam logic [2:0] FN_SUB = 3'd1;
    localparam logic [2:0] FN_AND = 3'd2;
    localparam logic [2:0] FN_OR  = 3'd3;
    localparam logic [2:0] FN_XOR = 3'd4;
    localparam logic [2:0] FN_SLT = 3'd5;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5
    } alu_op_e;

    // Unused functs fall back to ADD; the write is suppressed in WB instead.
    function automatic alu_op_e funct_to_alu(input logic [2:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_XOR:  return ALU_XOR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU; zero flag is taken on the result so a SUB doubles as an
// equality compare for branches.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  alu_op_e           op_i,
    output logic [DATA_W-1:0] y_o,
    output logic              zero_o
);

    always_comb begin
        y_o = '0;
        case (op_i)
            ALU_ADD: y_o = a_i + b_i;
            ALU_SUB: y_o = a_i - b_i;
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
            ALU_XOR: y_o = a_i ^ b_i;
            ALU_SLT: y_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            default: y_o = '0;
        endcase
    end

    assign zero_o = (y_o == '0);

endmodule

// File: rtl/cpu_multicycle.sv
// Multi-cycle CPU: FETCH/DECODE/EXEC/MEM/WB sequencer sharing one
// valid/ready memory port for instructions and data.
module cpu_multicycle
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
) (
    input  logic              Clock,
    input  logic              Reset_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              halted,
    output logic [ADDR_W-1:0] pc
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, alu_q, alu_d;
    logic [DATA_W-1:0]   regs_q [4];

    logic                rf_we;
    logic [1:0]          rf_wa;
    logic                req, we;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;

    logic [3:0]          op;
    logic [1:0]          rs, rt, rd;
    logic [2:0]          funct;
    logic [DATA_W-1:0]   imm_d;
    logic [ADDR_W-1:0]   imm_a, jmp_tgt;

    assign op      = ir_q[15:12];
    assign rs      = ir_q[11:10];
    assign rt      = ir_q[9:8];
    assign rd      = ir_q[7:6];
    assign funct   = ir_q[2:0];
    assign imm_d   = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
    assign imm_a   = {{(ADDR_W-8){ir_q[7]}}, ir_q[7:0]};
    assign jmp_tgt = ADDR_W'(ir_q[11:0]);

    logic [DATA_W-1:0] alu_b, alu_y;
    logic              alu_zero;
    alu_op_e           alu_op;

    always_comb begin
        alu_b  = imm_d;
        alu_op = ALU_ADD;
        if (op == OP_RTYPE) begin
            alu_b  = b_q;
            alu_op = funct_to_alu(funct);
        end else if (op == OP_BEQ || op == OP_BNE) begin
            alu_b  = b_q;
            alu_op = ALU_SUB;
        end
    end

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .a_i    (a_q),
        .b_i    (alu_b),
        .op_i   (alu_op),
        .y_o    (alu_y),
        .zero_o (alu_zero)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        alu_d   = alu_q;
        rf_we   = 1'b0;
        rf_wa   = (op == OP_RTYPE) ? rd : rt;
        req     = 1'b0;
        we      = 1'b0;
        addr    = pc_q;
        wdata   = '0;
        case (state_q)
            S_FETCH: begin
                req = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata[15:0];
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = regs_q[rs];
                b_d     = regs_q[rt];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                alu_d   = alu_y;
                state_d = S_FETCH;
                case (op)
                    OP_RTYPE, OP_ADDI: state_d = S_WB;
                    OP_LW, OP_SW:      state_d = S_MEM;
                    OP_BEQ:            if (alu_zero)  pc_d = pc_q + imm_a;
                    OP_BNE:            if (!alu_zero) pc_d = pc_q + imm_a;
                    OP_JMP:            pc_d = jmp_tgt;
                    OP_HALT:           state_d = S_HALT;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                req  = 1'b1;
                addr = ADDR_W'(alu_q);
                if (op == OP_SW) begin
                    we    = 1'b1;
                    wdata = b_q;
                end
                if (mem_ready) begin
                    // Load data reuses the ALU latch so WB has a single source.
                    if (op == OP_LW) begin
                        alu_d   = mem_rdata;
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                rf_we   = (op != OP_RTYPE) || (funct <= FN_SLT);
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            if (rf_we) regs_q[rf_wa] <= alu_q;
        end
    end

    assign mem_req   = Reset_n & req;
    assign mem_we    = Reset_n & we;
    assign mem_addr  = addr;
    assign mem_wdata = Reset_n ? wdata : '0;
    assign halted    = Reset_n && (state_q == S_HALT);
    assign pc        = Reset_n ? pc_q : '0;

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench: ALU vector table plus hand-written wait-state, branch, wrap,
// halt and reset sequences on a 16-bit core, and one 32-bit datapath program.
module tb_cpu_multicycle;
    import cpu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst16 = 1'b0, rst32 = 1'b0;
    logic        req16, we16, rdy16, halt16;
    logic [11:0] addr16, pc16;
    logic [15:0] wdata16, rdata16;
    logic        req32, we32, rdy32, halt32;
    logic [11:0] addr32, pc32;
    logic [31:0] wdata32, rdata32;

    cpu_multicycle #(.DATA_W(16), .ADDR_W(12)) dut16 (
        .Clock(clk), .Reset_n(rst16), .mem_req(req16), .mem_we(we16),
        .mem_addr(addr16), .mem_wdata(wdata16), .mem_ready(rdy16),
        .mem_rdata(rdata16), .halted(halt16), .pc(pc16));

    cpu_multicycle #(.DATA_W(32), .ADDR_W(12)) dut32 (
        .Clock(clk), .Reset_n(rst32), .mem_req(req32), .mem_we(we32),
        .mem_addr(addr32), .mem_wdata(wdata32), .mem_ready(rdy32),
        .mem_rdata(rdata32), .halted(halt32), .pc(pc32));

    // 16-bit memory: program image from the stimulus, stored words overlay it.
    logic [15:0] rom16 [4096];
    logic [15:0] ram16 [4096];
    logic        wv16  [4096];
    int          waits16 = 0;
    int          wcnt16 = 0, cyc16 = 0;
    int          rd_n = 0, st_n = 0;
    logic [11:0] rd_addr [64];
    int          rd_cyc  [64];
    logic [11:0] st_addr [16];
    logic [15:0] st_data [16];
    int          st_cyc  [16];
    int          viol16 = 0, stab16 = 0;
    logic        pw = 1'b0, pwe = 1'b0;
    logic [11:0] paddr = '0;
    logic [15:0] pwd = '0;

    assign rdy16   = req16 && (wcnt16 == waits16);
    assign rdata16 = !rdy16 ? 16'h0 : (wv16[addr16] ? ram16[addr16] : rom16[addr16]);

    always @(posedge clk) begin
        if (!rst16) begin
            cyc16 <= 0; wcnt16 <= 0; rd_n <= 0; st_n <= 0; pw <= 1'b0;
            for (int i = 0; i < 4096; i++) wv16[i] <= 1'b0;
        end else begin
            cyc16  <= cyc16 + 1;
            wcnt16 <= (req16 && !rdy16) ? wcnt16 + 1 : 0;
            if (pw) begin
                stab16 <= stab16 + 1;
                if (!req16 || addr16 !== paddr || we16 !== pwe || wdata16 !== pwd)
                    viol16 <= viol16 + 1;
            end
            pw <= req16 && !rdy16; paddr <= addr16; pwe <= we16; pwd <= wdata16;
            if (req16 && rdy16) begin
                if (we16) begin
                    ram16[addr16] <= wdata16; wv16[addr16] <= 1'b1;
                    if (st_n < 16) begin
                        st_addr[st_n] <= addr16; st_data[st_n] <= wdata16;
                        st_cyc[st_n] <= cyc16 + 1; st_n <= st_n + 1;
                    end
                end else if (rd_n < 64) begin
                    rd_addr[rd_n] <= addr16; rd_cyc[rd_n] <= cyc16 + 1; rd_n <= rd_n + 1;
                end
            end
        end
    end

    // 32-bit memory: zero-wait program image, stores only logged.
    logic [31:0] rom32 [4096];
    int          st32_n = 0;
    logic [11:0] st32_addr [8];
    logic [31:0] st32_data [8];
    assign rdy32   = req32;
    assign rdata32 = rdy32 ? rom32[addr32] : 32'h0;

    always @(posedge clk) begin
        if (!rst32) st32_n <= 0;
        else if (req32 && we32 && st32_n < 8) begin
            st32_addr[st32_n] <= addr32; st32_data[st32_n] <= wdata32; st32_n <= st32_n + 1;
        end
    end

    int n_cmp = 0, n_fail = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] rt_i(input logic [1:0] rs, input logic [1:0] rt,
                                         input logic [1:0] rd, input logic [2:0] f);
        return {OP_RTYPE, rs, rt, rd, 3'b000, f};
    endfunction
    function automatic logic [15:0] it_i(input logic [3:0] op, input logic [1:0] rs,
                                         input logic [1:0] rt, input logic [7:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic hold16(input int w);
        @(negedge clk); rst16 = 1'b0; waits16 = w;
        for (int i = 0; i < 4096; i++) rom16[i] = 16'hF000;
    endtask
    task automatic release16;
        repeat (2) @(negedge clk);
        rst16 = 1'b1;
    endtask
    task automatic run16(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (halt16) begin ok = 1'b1; break; end
        end
    endtask

    typedef struct {
        string       name;
        logic [15:0] instr;
        logic [15:0] exp;
    } vec_t;
    vec_t vt [9];

    initial begin
        bit ok;
        int hi;
        vt[0] = '{"ADD",   rt_i(2'd1, 2'd2, 2'd3, FN_ADD), 16'h0002};
        vt[1] = '{"SUB",   rt_i(2'd1, 2'd2, 2'd3, FN_SUB), 16'h0008};
        vt[2] = '{"AND",   rt_i(2'd1, 2'd2, 2'd3, FN_AND), 16'h0005};
        vt[3] = '{"OR",    rt_i(2'd1, 2'd2, 2'd3, FN_OR),  16'hFFFD};
        vt[4] = '{"XOR",   rt_i(2'd1, 2'd2, 2'd3, FN_XOR), 16'hFFF8};
        vt[5] = '{"SLTt",  rt_i(2'd2, 2'd1, 2'd3, FN_SLT), 16'h0001};
        vt[6] = '{"SLTf",  rt_i(2'd1, 2'd2, 2'd3, FN_SLT), 16'h0000};
        vt[7] = '{"FN6",   rt_i(2'd1, 2'd2, 2'd3, 3'd6),   16'h0000};
        vt[8] = '{"ADDI",  it_i(OP_ADDI, 2'd1, 2'd3, 8'hFA), 16'hFFFF};

        // Reset state
        hold16(0);
        @(negedge clk);
        check("rst_req", 32'(req16), 32'd0);
        check("rst_halted", 32'(halt16), 32'd0);
        check("rst_pc", 32'(pc16), 32'd0);

        // ALU table: R1=5, R2=-3, op under test writes R3, R3 stored to 100
        for (int v = 0; v < 9; v++) begin
            hold16(0);
            rom16[0] = it_i(OP_ADDI, 2'd0, 2'd1, 8'd5);
            rom16[1] = it_i(OP_ADDI, 2'd0, 2'd2, 8'hFD);
            rom16[2] = vt[v].instr;
            rom16[3] = it_i(OP_SW, 2'd0, 2'd3, 8'd100);
            release16();
            run16(80, ok);
            check({vt[v].name, "_halt"}, 32'(ok), 32'd1);
            check({vt[v].name, "_data"}, 32'(st_data[0]), 32'(vt[v].exp));
            if (v == 0) begin
                check("ADD_st_addr", 32'(st_addr[0]), 32'd100);
                check("ADD_st_cyc", 32'(st_cyc[0]), 32'd16);
            end
        end

        // SW/LW through a 2-wait-state memory
        hold16(2);
        rom16[0] = it_i(OP_ADDI, 2'd0, 2'd1, 8'd5);
        rom16[1] = it_i(OP_SW, 2'd0, 2'd1, 8'd7);
        rom16[2] = it_i(OP_LW, 2'd0, 2'd2, 8'd7);
        rom16[3] = it_i(OP_SW, 2'd0, 2'd2, 8'd8);
        release16();
        run16(200, ok);
        check("mem_halt", 32'(ok), 32'd1);
        check("mem_st_n", st_n, 32'd2);
        check("sw_addr", 32'(st_addr[0]), 32'd7);
        check("sw_data", 32'(st_data[0]), 32'd5);
        check("sw_cyc", st_cyc[0], 32'd14);
        check("lw_st_addr", 32'(st_addr[1]), 32'd8);
        check("lw_data", 32'(st_data[1]), 32'd5);

        // Branches: BEQ at 4 taken once back to 3, then BEQ and BNE fall through
        hold16(0);
        rom16[0] = it_i(OP_ADDI, 2'd0, 2'd1, 8'd1);
        rom16[1] = 16'h7000;
        rom16[2] = 16'h8000;
        rom16[3] = it_i(OP_ADDI, 2'd2, 2'd2, 8'd1);
        rom16[4] = it_i(OP_BEQ, 2'd2, 2'd1, 8'hFE);
        rom16[5] = it_i(OP_BNE, 2'd1, 2'd1, 8'd5);
        release16();
        run16(120, ok);
        check("br_halt", 32'(ok), 32'd1);
        check("br_rd_n", rd_n, 32'd9);
        begin
            int exp_pc [9] = '{0, 1, 2, 3, 4, 3, 4, 5, 6};
            for (int i = 0; i < 9; i++)
                check($sformatf("br_fetch%0d", i), 32'(rd_addr[i]), exp_pc[i]);
        end
        check("halt_pc", 32'(pc16), 32'd7);
        hi = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (req16 || !halt16) hi++;
        end
        check("halt_quiet", hi, 32'd0);
        @(negedge clk); rst16 = 1'b0;
        release16();
        @(negedge clk);
        check("restart_n", rd_n, 32'd1);
        check("restart_addr", 32'(rd_addr[0]), 32'd0);
        check("restart_cyc", rd_cyc[0], 32'd1);

        // JMP 0xFFF, NOP there, PC wraps to 0 on fetch
        hold16(0);
        rom16[0]     = {OP_JMP, 12'hFFF};
        rom16[12'hFFF] = 16'h7000;
        release16();
        repeat (7) @(negedge clk);
        check("jmp_rd_n", rd_n, 32'd3);
        check("jmp_tgt", 32'(rd_addr[1]), 32'hFFF);
        check("wrap_addr", 32'(rd_addr[2]), 32'd0);
        check("wrap_cyc", rd_cyc[2], 32'd7);
        check("fetch_wdata", 32'(wdata16), 32'd0);

        // Reset during a LW data wait
        hold16(4);
        rom16[0]  = it_i(OP_LW, 2'd0, 2'd1, 8'd20);
        rom16[20] = 16'h1234;
        release16();
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req16 && !we16 && addr16 == 12'd20) begin ok = 1'b1; break; end
        end
        check("lw_wait_seen", 32'(ok), 32'd1);
        repeat (2) @(negedge clk);
        check("lw_pending", rd_n, 32'd1);
        rst16 = 1'b0;
        @(negedge clk);
        check("rst_mid_req", 32'(req16), 32'd0);
        @(negedge clk); rst16 = 1'b1;
        @(negedge clk);
        check("refetch_req", 32'(req16), 32'd1);
        check("refetch_addr", 32'(addr16), 32'd0);
        check("stable_seen", 32'(stab16 > 0), 32'd1);
        check("stable_viol", viol16, 32'd0);

        // 32-bit datapath
        for (int i = 0; i < 4096; i++) rom32[i] = 32'h0000F000;
        rom32[0] = 32'(it_i(OP_ADDI, 2'd0, 2'd1, 8'hFF));
        rom32[1] = 32'(rt_i(2'd1, 2'd1, 2'd1, FN_ADD));
        rom32[2] = 32'(rt_i(2'd1, 2'd0, 2'd2, FN_SLT));
        rom32[3] = 32'(it_i(OP_SW, 2'd0, 2'd1, 8'd50));
        rom32[4] = 32'(it_i(OP_SW, 2'd0, 2'd2, 8'd51));
        @(negedge clk); rst32 = 1'b0;
        repeat (2) @(negedge clk); rst32 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (halt32) begin ok = 1'b1; break; end
        end
        check("w32_halt", 32'(ok), 32'd1);
        check("w32_st_n", st32_n, 32'd2);
        check("w32_addr", 32'(st32_addr[0]), 32'd50);
        check("w32_add", st32_data[0], 32'hFFFFFFFE);
        check("w32_slt", st32_data[1], 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
